// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - op encodings, sweep FSM states and expected sweep counts
package gate_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int ONES_W = 9;

  // Number of 1-results over all 2^n_in input patterns of an n_in-input gate.
  function automatic logic [ONES_W-1:0] exp_ones(input logic [2:0] op, input int n_in);
    logic [ONES_W-1:0] full;
    logic [ONES_W-1:0] half;
    full = ONES_W'((1 << n_in) - 1);
    half = ONES_W'(1 << (n_in - 1));
    case (op)
      OP_AND, OP_NOR:   exp_ones = ONES_W'(1);
      OP_OR, OP_NAND:   exp_ones = full;
      OP_XOR, OP_XNOR:  exp_ones = half;
      default:          exp_ones = '0;
    endcase
  endfunction

endpackage

// File: rtl/gate_core.sv
// rtl/gate_core.sv - combinational N_IN-input gate replicated over W bit lanes
module gate_core
  import gate_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int W    = 1
) (
  input  logic [2:0]        op_i,
  input  logic [N_IN*W-1:0] operands_i,
  output logic [W-1:0]      result_o
);

  for (genvar j = 0; j < W; j++) begin : g_lane
    logic [N_IN-1:0] v;
    logic            r;

    // Operand k of lane j sits at bit k*W+j.
    for (genvar k = 0; k < N_IN; k++) begin : g_opnd
      assign v[k] = operands_i[k*W+j];
    end

    always_comb begin
      r = 1'b0;
      case (op_i)
        OP_AND:  r = &v;
        OP_OR:   r = |v;
        OP_NAND: r = ~&v;
        OP_NOR:  r = ~|v;
        OP_XOR:  r = ^v;
        OP_XNOR: r = ~^v;
        default: r = 1'b0;
      endcase
    end

    assign result_o[j] = r;
  end

endmodule

// File: rtl/gate_sweep_unit.sv
// rtl/gate_sweep_unit.sv - gate datapath with one-entry output register; sweep self-check under GATE_SWEEP_EN
module gate_sweep_unit
  import gate_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int W    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        op,
  input  logic              in_valid,
  input  logic [N_IN*W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  input  logic              sweep_start,
  output logic              sweep_busy,
  output logic              sweep_done,
  output logic [N_IN:0]     sweep_ones,
  output logic              sweep_err
);

  localparam int ACC_W = N_IN + 1;

  logic [W-1:0] gate_res;
  logic         xfer_w;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;

  gate_core #(.N_IN(N_IN), .W(W)) u_core (
    .op_i       (op),
    .operands_i (in_data),
    .result_o   (gate_res)
  );

  assign xfer_w = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (xfer_w) begin
      out_valid_d = 1'b1;
      out_data_d  = gate_res;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef GATE_SWEEP_EN
  state_e            state_q;
  logic [2:0]        op_q;
  logic [N_IN-1:0]   cnt_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_next;
  logic [ACC_W-1:0]  ones_q;
  logic              busy_q, done_q, err_q;
  logic              lane_res;

  // Sweep lane sees the pattern counter directly: bit k drives operand k.
  gate_core #(.N_IN(N_IN), .W(1)) u_lane (
    .op_i       (op_q),
    .operands_i (cnt_q),
    .result_o   (lane_res)
  );

  assign acc_next = acc_q + ACC_W'(lane_res);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ones_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sweep_start && !out_valid_q) begin
            state_q <= ST_SWEEP;
            busy_q  <= 1'b1;
            op_q    <= op;
            cnt_q   <= '0;
            acc_q   <= '0;
          end
        end
        ST_SWEEP: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + N_IN'(1);
          if (&cnt_q) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            ones_q  <= acc_next;
            err_q   <= (acc_next != ACC_W'(exp_ones(op_q, N_IN)));
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = rst_n && (state_q == ST_IDLE) && !sweep_start && (!out_valid_q || out_ready);
  assign sweep_busy = busy_q;
  assign sweep_done = done_q;
  assign sweep_ones = ones_q;
  assign sweep_err  = err_q;
`else
  logic unused_sweep_start;

  assign unused_sweep_start = sweep_start;
  assign in_ready   = rst_n && (!out_valid_q || out_ready);
  assign sweep_busy = 1'b0;
  assign sweep_done = 1'b0;
  assign sweep_ones = '0;
  assign sweep_err  = 1'b0;
`endif

endmodule

// File: tb/tb_gate_sweep_unit.sv
// tb/tb_gate_sweep_unit.sv - scoreboard bench for gate_sweep_unit (N_IN=3, W=4), sweep checks under GATE_SWEEP_EN
module tb_gate_sweep_unit;

  localparam int N_IN = 3;
  localparam int W    = 4;

  logic              clk;
  logic              rst_n;
  logic [2:0]        op;
  logic              in_valid;
  logic [N_IN*W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic              sweep_start;
  logic              sweep_busy;
  logic              sweep_done;
  logic [N_IN:0]     sweep_ones;
  logic              sweep_err;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic         prev_xfer = 1'b0;
  logic         rand_ready = 1'b0;

  gate_sweep_unit #(.N_IN(N_IN), .W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (op),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .sweep_ones  (sweep_ones),
    .sweep_err   (sweep_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [N_IN*W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int j = 0; j < W; j++) begin
      int ones;
      ones = 0;
      for (int k = 0; k < N_IN; k++) ones += int'(d[k*W+j]);
      case (o)
        3'd0: r[j] = (ones == N_IN);
        3'd1: r[j] = (ones != 0);
        3'd2: r[j] = (ones != N_IN);
        3'd3: r[j] = (ones == 0);
        3'd4: r[j] = (ones % 2 == 1);
        3'd5: r[j] = (ones % 2 == 0);
        default: r[j] = 1'b0;
      endcase
    end
    return r;
  endfunction

  function automatic logic [N_IN*W-1:0] rep(input logic [N_IN-1:0] p);
    logic [N_IN*W-1:0] d;
    for (int k = 0; k < N_IN; k++) d[k*W +: W] = {W{p[k]}};
    return d;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_xfer = 1'b0;
    end else begin
      if (prev_xfer) chk("latency", out_valid, 1);
      if (out_valid) begin
        if (exp_q.size() == 0) chk("sb_depth", exp_q.size(), 1);
        else if (out_ready) chk("out_data", out_data, exp_q.pop_front());
        else begin
          chk("hold_data", out_data, exp_q[0]);
          chk("hold_in_ready", in_ready, 0);
        end
      end
      prev_xfer = in_valid && in_ready;
      if (prev_xfer) exp_q.push_back(model(op, in_data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] o, input logic [N_IN*W-1:0] d);
    bit done;
    op = o;
    in_data = d;
    in_valid = 1'b1;
    done = 0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      done = in_ready;
      tick();
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
    if (!done) chk("send_timeout", in_ready, 1);
    in_valid = 1'b0;
  endtask

`ifdef GATE_SWEEP_EN
  task automatic run_sweep(input logic [2:0] sop, input bit with_valid);
    int exp_n, busy_n, done_n;
    logic [N_IN:0] ones;
    logic err;
    logic [N_IN*W-1:0] d;
    exp_n = 0;
    for (int p = 0; p < (1 << N_IN); p++) begin
      d = '0;
      for (int k = 0; k < N_IN; k++) d[k*W] = p[k];
      exp_n += int'(model(sop, d)[0]);
    end
    op = sop;
    sweep_start = 1'b1;
    if (with_valid) begin
      in_valid = 1'b1;
      in_data = 12'($urandom);
    end
    @(negedge clk);
    if (with_valid) chk("start_in_ready", in_ready, 0);
    tick();
    sweep_start = 1'b0;
    in_valid = 1'b0;
    op = ~sop;
    busy_n = 0;
    done_n = 0;
    ones = '0;
    err = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (sweep_busy) busy_n++;
      if (sweep_done) begin
        done_n++;
        ones = sweep_ones;
        err = sweep_err;
      end else if (done_n > 0) break;
    end
    chk("sweep_busy_cycles", busy_n, 8);
    chk("sweep_done_pulses", done_n, 1);
    chk("sweep_ones", ones, exp_n);
    chk("sweep_err", err, 0);
    tick();
    repeat (2) tick();
    chk("sweep_ones_hold", sweep_ones, exp_n);
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    op = 3'd0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    sweep_start = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", sweep_busy, 0);
    chk("rst_done", sweep_done, 0);
    chk("rst_ones", sweep_ones, 0);
    chk("rst_err", sweep_err, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // NAND over 000, 110, 111, 101, back to back
    send(3'd2, rep(3'b000));
    send(3'd2, rep(3'b110));
    send(3'd2, rep(3'b111));
    send(3'd2, rep(3'b101));
    repeat (2) tick();

    // XOR lanes a=1010 b=0110 c=0011 held under backpressure
    out_ready = 1'b0;
    send(3'd4, {4'b0011, 4'b0110, 4'b1010});
    repeat (3) begin
      @(negedge clk);
      chk("xor_held", out_data, 4'hF);
      chk("xor_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    repeat (2) tick();

    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) send(3'($urandom_range(0, 7)), 12'($urandom));
    rand_ready = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

`ifdef GATE_SWEEP_EN
    run_sweep(3'd0, 0);
    run_sweep(3'd4, 0);
    run_sweep(3'd2, 0);
    run_sweep(3'd6, 0);

    // sweep_start while a result is pending is dropped
    out_ready = 1'b0;
    send(3'd1, 12'h0F0);
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("ignored_busy", sweep_busy, 0);
      tick();
    end
    out_ready = 1'b1;
    repeat (3) tick();
    chk("ignored_busy_after", sweep_busy, 0);

    run_sweep(3'd3, 1);

    // reset in the middle of a sweep
    run_sweep(3'd1, 0);
    op = 3'd4;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    repeat (3) tick();
    chk("busy_pre_rst", sweep_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", sweep_busy, 0);
    chk("mid_rst_done", sweep_done, 0);
    chk("mid_rst_ones", sweep_ones, 0);
    chk("mid_rst_err", sweep_err, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", sweep_done, 0);
    end
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_done", sweep_done, 0);
      chk("post_rst_busy", sweep_busy, 0);
    end
    tick();
    run_sweep(3'd5, 0);
    send(3'd0, rep(3'b111));
    repeat (2) tick();
`else
    // sweep_start has no effect; datapath keeps accepting
    op = 3'd5;
    in_data = 12'h5A3;
    in_valid = 1'b1;
    sweep_start = 1'b1;
    @(negedge clk);
    chk("nosweep_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    sweep_start = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("nosweep_busy", sweep_busy, 0);
      chk("nosweep_done", sweep_done, 0);
      chk("nosweep_ones", sweep_ones, 0);
      chk("nosweep_err", sweep_err, 0);
      tick();
    end
    send(3'd1, rep(3'b010));
    repeat (2) tick();
`endif

    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_sweep_unit.md
GATE_SWEEP_UNIT -- requirements
Module: gate_sweep_unit

Interface
REQ-001 The block SHALL have parameter N_IN, default 3, giving gate input count (legal 2..8).
REQ-002 The block SHALL have parameter W, default 1, giving the number of independent bit lanes (legal 1..32).
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port op, input, 3: gate select; 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6-7 reserved.
REQ-006 Port in_valid, input, 1: in_data holds a valid operand set.
REQ-007 Port in_data, input, N_IN*W: operand k of lane j is bit k*W+j.
REQ-008 Port in_ready, output, 1: block accepts in_data this cycle.
REQ-009 Port out_valid, output, 1: out_data holds a valid result.
REQ-010 Port out_ready, input, 1: downstream consumes out_data this cycle.
REQ-011 Port out_data, output, W: per-lane gate result.
REQ-012 Port sweep_start, input, 1: request an exhaustive self-check sweep.
REQ-013 Port sweep_busy, output, 1: sweep in progress.
REQ-014 Port sweep_done, output, 1: one-cycle pulse when a sweep completes.
REQ-015 Port sweep_ones, output, N_IN+1: number of swept patterns that yielded 1.
REQ-016 Port sweep_err, output, 1: sweep_ones differed from the expected count for the latched op.

Function
REQ-017 Each lane SHALL compute the selected N_IN-input gate over its operands; XOR is the odd-parity function and XNOR its inverse; reserved ops SHALL yield 0.
REQ-018 Output SHALL be a one-entry register: a transfer occurs when in_valid && in_ready, and the result appears on out_data with out_valid high on the next cycle (latency 1).
REQ-019 in_ready SHALL equal (state==IDLE) && !sweep_start && (!out_valid || out_ready), so back-to-back transfers sustain one per cycle.
REQ-020 out_valid SHALL clear after out_valid && out_ready unless a new transfer occurs in the same cycle; out_data SHALL stay stable while out_valid && !out_ready.
REQ-021 The FSM SHALL have the states IDLE, SWEEP and DONE.
REQ-022 IDLE -> SWEEP SHALL occur when sweep_start is high, state is IDLE and out_valid is 0; otherwise sweep_start SHALL be ignored and not queued.
REQ-023 On entering SWEEP, op SHALL be latched, the pattern counter set to 0 and the ones accumulator set to 0.
REQ-024 In SWEEP, each cycle SHALL apply the counter value as the N_IN operand bits (bit k = operand k) to one gate lane, add its result to the accumulator, and increment the counter; the sweep lasts exactly 2^N_IN cycles.
REQ-025 After the pattern 2^N_IN-1 is processed, the FSM SHALL go to DONE, sweep_ones and sweep_err SHALL update, and sweep_done SHALL pulse for that one cycle; DONE SHALL then go to IDLE unconditionally.
REQ-026 Expected counts SHALL be: AND 1, NOR 1, OR 2^N_IN-1, NAND 2^N_IN-1, XOR 2^(N_IN-1), XNOR 2^(N_IN-1), reserved 0.
REQ-027 sweep_busy SHALL be high exactly in SWEEP; sweep_ones and sweep_err SHALL hold until the next DONE.
REQ-028 op changes during SWEEP SHALL have no effect on the running sweep.

Reset
REQ-029 Assertion of rst_n low SHALL immediately force IDLE, out_valid=0, out_data=0, sweep_busy=0, sweep_done=0, sweep_ones=0, sweep_err=0 and counter=0, including mid-sweep; an aborted sweep SHALL produce no sweep_done.
REQ-030 in_ready SHALL be 0 while rst_n is low.

Configuration
REQ-031 With macro GATE_SWEEP_EN defined, the sweep FSM, counter and checker SHALL be present as specified.
REQ-032 Without GATE_SWEEP_EN, sweep_start SHALL be ignored, sweep_busy/sweep_done/sweep_err SHALL be tied 0, sweep_ones SHALL be tied 0, and the state SHALL remain IDLE.

Structure
REQ-033 Package gate_pkg SHALL hold the op encodings, the FSM state encoding and the expected-count function of (op, N_IN).
REQ-034 Sub-module gate_core SHALL implement the combinational N_IN-input, W-lane gate; it SHALL be instantiated once for the datapath and once (W=1) for the sweep lane.

Verification
REQ-035 N_IN=3, W=1, op=NAND; in_data 000, 110, 111, 101 on consecutive cycles with out_ready=1 -> out_data 1, 1, 0, 1, each one cycle after acceptance.
REQ-036 W=4, op=XOR, in_data lanes {a=1010, b=0110, c=0011}, out_ready=0 for 3 cycles -> out_data=1111 held stable and in_ready=0 until out_ready rises.
REQ-037 N_IN=3, op=AND, sweep_start pulse -> sweep_busy high for 8 cycles, then sweep_done pulses for one cycle with sweep_ones=1 and sweep_err=0; op=XOR -> sweep_ones=4.
REQ-038 sweep_start while out_valid=1 -> ignored and sweep_busy stays 0; sweep_start together with in_valid in IDLE -> sweep starts and in_ready=0.
REQ-039 rst_n low at sweep cycle 4 -> all outputs 0 immediately, no sweep_done; a new sweep after release completes normally.
REQ-040 Build without GATE_SWEEP_EN; sweep_start pulse -> sweep_busy/sweep_done stay 0 and the datapath is unaffected.
